// File: rtl/arraymultiplier_wide_seq.sv
// 2N x 2N unsigned multiplier built from one shared N x N array multiplier.
// Four half-products pass through the array one per cycle and are summed shifted.

module arraymultiplier #(
    parameter int N = 16
) (
    input  logic [N-1:0]   x,
    input  logic [N-1:0]   y,
    output logic [2*N-1:0] prod
);
    // Ripple of shifted partial-product rows; row gi adds x<<gi when y[gi] is set
    for (genvar gi = 0; gi < N; gi++) begin : g_row
        logic [2*N-1:0] row_pp;
        logic [2*N-1:0] row_sum;
        assign row_pp = y[gi] ? ({{N{1'b0}}, x} << gi) : '0;
        if (gi == 0) begin : g_first
            assign row_sum = row_pp;
        end else begin : g_rest
            assign row_sum = g_row[gi-1].row_sum + row_pp;
        end
    end
    assign prod = g_row[N-1].row_sum;
endmodule

module arraymultiplier_wide_seq #(
    parameter int N = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] a,
    input  logic [2*N-1:0] b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [4*N-1:0] p,
    output logic           busy
);
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t         state_reg, state_next;
    logic [1:0]     step_reg;
    logic [2*N-1:0] a_reg, b_reg;
    logic [4*N-1:0] acc_reg;

    logic [N-1:0]   mul_x, mul_y;
    logic [2*N-1:0] half_prod;
    logic [4*N-1:0] prod_ext;
    logic [4*N-1:0] addend;

    // Half selection by step: LL, HL, LH, HH
    always_comb begin
        mul_x = a_reg[N-1:0];
        mul_y = b_reg[N-1:0];
        case (step_reg)
            2'd1: begin mul_x = a_reg[2*N-1:N]; mul_y = b_reg[N-1:0];   end
            2'd2: begin mul_x = a_reg[N-1:0];   mul_y = b_reg[2*N-1:N]; end
            2'd3: begin mul_x = a_reg[2*N-1:N]; mul_y = b_reg[2*N-1:N]; end
            default: ;
        endcase
    end

    arraymultiplier #(.N(N)) u_array (
        .x    (mul_x),
        .y    (mul_y),
        .prod (half_prod)
    );

    assign prod_ext = {{(2*N){1'b0}}, half_prod};

    always_comb begin
        addend = prod_ext;
        case (step_reg)
            2'd1, 2'd2: addend = prod_ext << N;
            2'd3:       addend = prod_ext << (2*N);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_next = MUL;
            end
            MUL: begin
                if (step_reg == 2'd3) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operands are captured on acceptance so a/b may change while multiplying
    always_ff @(posedge clk) begin
        if (rst) begin
            step_reg <= 2'd0;
            acc_reg  <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_reg    <= a;
                        b_reg    <= b;
                        acc_reg  <= '0;
                        step_reg <= 2'd0;
                    end
                end
                MUL: begin
                    acc_reg  <= acc_reg + addend;
                    step_reg <= step_reg + 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign p = acc_reg;
endmodule

// File: tb/tb_arraymultiplier_wide_seq.sv
// Scoreboard bench: accepted operand pairs queue a*b, a monitor pops on each
// output handshake; directed cases cover latency, stalls and mid-job reset.

module tb_arraymultiplier_wide_seq;
    localparam int N = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [2*N-1:0] a, b;
    logic           out_valid;
    logic           out_ready;
    logic [4*N-1:0] p;
    logic           busy;

    int tests = 0;
    int fails = 0;
    int sent = 0;
    int popped = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    arraymultiplier_wide_seq #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("[TB] ok %s: %h", name, act);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Issue side: every accepted pair queues its reference product
    always @(negedge clk) begin
        if (!rst && in_valid && in_ready) begin
            exp_q.push_back(64'(a) * 64'(b));
            sent++;
        end
    end

    // Monitor: compares each presented product against the oldest expectation
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output: got %h expected none", p);
            end else begin
                check("product", p, exp_q.pop_front());
            end
            popped++;
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge
    task automatic send(input logic [31:0] av, input logic [31:0] bv);
        int n = 0;
        a = av;
        b = bv;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) fail_now("send_timeout");
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_out_valid();
        int n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk);
            #1 n++;
        end
        if (!out_valid) fail_now("out_valid_timeout");
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || !in_ready) && n < 2000) begin
            @(posedge clk);
            #1 n++;
        end
        if (n >= 2000) fail_now("drain_timeout");
    endtask

    task automatic run_expect(input string name, input logic [31:0] av,
                              input logic [31:0] bv, input logic [63:0] exp);
        send(av, bv);
        wait_out_valid();
        check(name, p, exp);
        drain();
    endtask

    initial begin
        int lat;
        logic [63:0] held;
        logic saw_valid;
        logic rand_done;

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_p", p, 64'd0);

        // Latency: out_valid visible right after the fourth edge past acceptance
        @(posedge clk);
        #1 out_ready = 1'b1;
        send(32'd3, 32'd5);
        check("busy_after_accept", 64'(busy), 64'd1);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        check("latency", 64'(lat), 64'd4);
        check("p_3x5", p, 64'd15);
        @(posedge clk);
        #1 check("in_ready_after_done", 64'(in_ready), 64'd1);
        drain();

        run_expect("p_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        run_expect("p_cross", 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000);
        run_expect("p_zero", 32'h0000_0000, 32'hDEAD_BEEF, 64'd0);

        // Stall in DONE while the operand bus churns
        out_ready = 1'b0;
        send(32'h1234_5678, 32'h9ABC_DEF0);
        wait_out_valid();
        held = p;
        check("stall_p", held, 64'h0B00_EA4E_242D_2080);
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            a = $urandom;
            b = $urandom;
            if (out_valid !== 1'b1 || p !== held || in_ready !== 1'b0) begin
                tests++;
                fails++;
                $display("FAIL stall_hold: got ov=%b p=%h ir=%b expected ov=1 p=%h ir=0",
                         out_valid, p, in_ready, held);
            end else begin
                tests++;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();

        // Reset while step 2 is in the register: job discarded
        send(32'd11, 32'd13);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        check("rst_mid_in_ready", 64'(in_ready), 64'd1);
        check("rst_mid_p", p, 64'd0);
        saw_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1 if (out_valid) saw_valid = 1'b1;
        end
        check("rst_mid_no_output", 64'(saw_valid), 64'd0);
        run_expect("p_7x9", 32'd7, 32'd9, 64'd63);

        // Randomized back-to-back traffic with random consumer stalls
        sent = 0;
        popped = 0;
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 100; i++) begin
                    send($urandom, $urandom);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1 out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        drain();
        @(posedge clk);
        #1 check("random_count", 64'(popped), 64'(sent));
        check("random_sent", 64'(sent), 64'd100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
